// File: rtl/types.sv
// Shared pipeline types: instruction record, opcode macros and memory-stage constants.
`ifndef TYPES_SV
`define TYPES_SV

`define OPC_ADD   7'h01
`define OPC_SUB   7'h02
`define OPC_LOAD  7'h10
`define OPC_STORE 7'h11

package types;

  typedef struct packed {
    logic       is_valid;
    logic [6:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } InstructionDetails;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } MemState;

  localparam logic [1:0] MEM_ALIGN_MASK = 2'b11;

endpackage

`endif

// File: rtl/memory_access.sv
// Memory pipeline stage: passes ALU results through and performs word loads/stores
// over a req/ack bus, stalling upstream until the access completes or times out.
module memory_access
  import types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              rst_async,
  input  logic              clk,
  input  InstructionDetails in_details,
  input  logic [31:0]       in_result,
  input  logic [31:0]       in_store_data,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output InstructionDetails out_details,
  output logic [31:0]       out_data,
  output logic              fault
);

  MemState           state;
  InstructionDetails held_details;
  logic [15:0]       timeout_cnt;
  logic              mem_op;
  logic              aligned;
  logic              timed_out;

  assign mem_op    = in_details.is_valid &&
                     (in_details.op inside {`OPC_LOAD, `OPC_STORE});
  assign aligned   = (in_result[1:0] & MEM_ALIGN_MASK) == 2'b00;
  assign timed_out = !mem_ack && (timeout_cnt == 16'(TIMEOUT_CYCLES));

  // An ack in the timeout cycle wins, so stall only drops on ack or expiry.
  always_comb begin
    stall = 1'b0;
    if (state == IDLE) begin
      stall = mem_op && aligned;
    end else begin
      stall = !mem_ack && !timed_out;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state        <= IDLE;
      held_details <= '0;
      timeout_cnt  <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      out_details  <= '0;
      out_data     <= '0;
      fault        <= 1'b0;
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: begin
          out_details <= in_details;
          out_data    <= in_result;
          if (mem_op) begin
            out_details.is_valid <= 1'b0;
            if (!aligned) begin
              fault <= 1'b1;
            end else begin
              held_details <= in_details;
              mem_addr     <= in_result;
              mem_wdata    <= in_store_data;
              mem_we       <= (in_details.op == `OPC_STORE);
              mem_req      <= 1'b1;
              timeout_cnt  <= '0;
              state        <= WAIT_ACK;
            end
          end
        end
        WAIT_ACK: begin
          out_details.is_valid <= 1'b0;
          if (mem_ack) begin
            mem_req     <= 1'b0;
            out_details <= held_details;
            out_data    <= mem_we ? mem_wdata : mem_rdata;
            state       <= IDLE;
          end else if (timed_out) begin
            mem_req <= 1'b0;
            fault   <= 1'b1;
            state   <= IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
